// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one RAM port between the instruction-fetch requester and the
// load/store data requester. One request is granted and its operands are
// latched. The RAM strobes are then held for RAM_LAT cycles, and a one-cycle
// done pulse goes back to the granted requester.
//
// Build option: define ARB_RR_EN for round-robin arbitration on a tie.
// Without it, data has fixed priority over fetch.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-low reset
//   if_req     fetch request (level, always a read)
//   if_addr    fetch address
//   if_done    one-cycle pulse: fetch complete, rdata valid
//   d_req      data request (level)
//   d_we       1 = store, 0 = load
//   d_addr     data address
//   d_wdata    store data
//   d_done     one-cycle pulse: data access complete
//   rdata      read data, valid while either done pulse is high
//   busy       transaction in progress (state != IDLE)
//   ram_cs     RAM chip select
//   ram_oe     RAM read enable
//   ram_we     RAM write enable
//   ram_addr   RAM address (latched at grant)
//   ram_wdata  RAM write data (latched at grant of a data request)
//   ram_rdata  RAM read data
//
// Handshake: a requester holds req and its operands stable until it sees its
// done pulse, and it drops req on the clock edge where done is high. A req
// that is still high in the IDLE cycle after RESP counts as a new request.
// Requests seen while busy are ignored; there is no queueing.
module mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int RAM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ram_cs,
  output logic              ram_oe,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(RAM_LAT - 1);

  state_t     state, state_next;
  logic [3:0] cnt;
  logic       owner_data;  // 1 = data requester owns the access in flight
  logic       lat_we;
  logic       grant_any;
  logic       grant_data;

`ifdef ARB_RR_EN
  logic       last_grant;  // 1 = data was granted last, 0 = fetch
`endif

  // Arbitration. On a tie, round-robin gives the grant to the requester
  // that was not granted last; fixed priority always gives it to data.
  always_comb begin
    grant_any = if_req | d_req;
`ifdef ARB_RR_EN
    grant_data = d_req & (~if_req | ~last_grant);
`else
    grant_data = d_req;
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_any) state_next = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= 4'd0;
      owner_data <= 1'b0;
      lat_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      rdata      <= '0;
`ifdef ARB_RR_EN
      last_grant <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner_data <= grant_data;
            lat_we     <= grant_data & d_we;
            ram_addr   <= grant_data ? d_addr : if_addr;
            // Fetches never write, so a fetch grant keeps the old store data.
            if (grant_data) ram_wdata <= d_wdata;
            cnt        <= CNT_INIT;
`ifdef ARB_RR_EN
            last_grant <= grant_data;
`endif
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            // Sample the RAM on the last strobe cycle. Stores leave rdata alone.
            if (!lat_we) rdata <= ram_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes are decoded from state only. Reset therefore drops them at once,
  // and oe/we can never be high without cs.
  assign busy    = (state != IDLE);
  assign ram_cs  = (state == ACCESS);
  assign ram_oe  = (state == ACCESS) & ~lat_we;
  assign ram_we  = (state == ACCESS) &  lat_we;
  assign if_done = (state == RESP) & ~owner_data;
  assign d_done  = (state == RESP) &  owner_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with RAM_LAT = 2.
// Inputs change and outputs are sampled on the falling edge. The design acts
// on the rising edge.
module tb_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          ram_cs;
  logic          ram_oe;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  int total;
  int bad;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .rdata     (rdata),
    .busy      (busy),
    .ram_cs    (ram_cs),
    .ram_oe    (ram_oe),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Wait for a done pulse, checking at most max_cyc falling edges.
  // Returns the number of cycles waited, or -1 if the budget ran out.
  task automatic wait_done(input bit want_data, input int max_cyc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      step();
      if ((want_data && d_done) || (!want_data && if_done)) begin
        cyc = i;
        break;
      end
    end
  endtask

  int n;
  int stray;

  initial begin
    total = 0; bad = 0;
    reset = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; ram_rdata = '0;

    // Reset state
    step(); step();
    chk("rst_busy",   {63'd0, busy},   64'd0);
    chk("rst_cs",     {63'd0, ram_cs}, 64'd0);
    chk("rst_rdata",  rdata,           64'd0);
    chk("rst_addr",   ram_addr,        64'd0);
    chk("rst_wdata",  ram_wdata,       64'd0);
    chk("rst_dones",  {62'd0, if_done, d_done}, 64'd0);
    reset = 1'b1;
    step();

    // Single fetch
    if_req = 1'b1; if_addr = 64'h1000; ram_rdata = 64'h00500093_00000000;
    step();  // cycle 1
    chk("f_c1_cs",   {63'd0, ram_cs}, 64'd1);
    chk("f_c1_oe",   {63'd0, ram_oe}, 64'd1);
    chk("f_c1_we",   {63'd0, ram_we}, 64'd0);
    chk("f_c1_addr", ram_addr,        64'h1000);
    chk("f_c1_busy", {63'd0, busy},   64'd1);
    step();  // cycle 2
    chk("f_c2_cs",   {63'd0, ram_cs}, 64'd1);
    chk("f_c2_oe",   {63'd0, ram_oe}, 64'd1);
    step();  // cycle 3
    chk("f_c3_ifdone", {63'd0, if_done}, 64'd1);
    chk("f_c3_ddone",  {63'd0, d_done},  64'd0);
    chk("f_c3_rdata",  rdata,            64'h00500093_00000000);
    chk("f_c3_cs",     {63'd0, ram_cs},  64'd0);
    if_req = 1'b0;
    step();  // cycle 4
    chk("f_c4_ifdone", {63'd0, if_done}, 64'd0);
    chk("f_c4_busy",   {63'd0, busy},    64'd0);

    // Store
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h2008; d_wdata = 64'hDEADBEEF_CAFEF00D;
    ram_rdata = 64'h5555_5555_5555_5555;
    step();
    chk("s_c1_we",    {63'd0, ram_we}, 64'd1);
    chk("s_c1_oe",    {63'd0, ram_oe}, 64'd0);
    chk("s_c1_addr",  ram_addr,        64'h2008);
    chk("s_c1_wdata", ram_wdata,       64'hDEADBEEF_CAFEF00D);
    step();
    chk("s_c2_we",    {63'd0, ram_we}, 64'd1);
    chk("s_c2_cs",    {63'd0, ram_cs}, 64'd1);
    step();
    chk("s_c3_ddone",  {63'd0, d_done},  64'd1);
    chk("s_c3_ifdone", {63'd0, if_done}, 64'd0);
    chk("s_c3_we",     {63'd0, ram_we},  64'd0);
    chk("s_c3_rdata",  rdata,            64'h00500093_00000000);
    d_req = 1'b0; d_we = 1'b0;
    step();

    // Load with an operand change during ACCESS
    d_req = 1'b1; d_addr = 64'h3000; ram_rdata = 64'h1111_2222_3333_4444;
    step();
    chk("l_c1_addr", ram_addr, 64'h3000);
    d_addr = 64'h4000;
    step();
    chk("l_c2_addr", ram_addr,        64'h3000);
    chk("l_c2_oe",   {63'd0, ram_oe}, 64'd1);
    step();
    chk("l_c3_ddone", {63'd0, d_done}, 64'd1);
    chk("l_c3_rdata", rdata,           64'h1111_2222_3333_4444);
    d_req = 1'b0;
    step();

    // Tie: data is served first, then fetch
    if_req = 1'b1; if_addr = 64'h6000; d_req = 1'b1; d_addr = 64'h5000;
    ram_rdata = 64'hAAAA_0000_0000_0001;
    step();
    chk("t_c1_addr", ram_addr, 64'h5000);
    wait_done(1'b1, 8, n);
    chk("t_ddone_lat", n, 2);
    chk("t_no_ifdone", {63'd0, if_done}, 64'd0);
    d_req = 1'b0;
    ram_rdata = 64'hBBBB_0000_0000_0002;
    wait_done(1'b0, 10, n);
    chk("t_gap",         n,      4);
    chk("t_fetch_rdata", rdata,  64'hBBBB_0000_0000_0002);
    chk("t_fetch_addr",  ram_addr, 64'h6000);
    if_req = 1'b0;
    step();

    // Reset in the middle of ACCESS
    if_req = 1'b1; if_addr = 64'h7000; ram_rdata = 64'hCCCC_0000_0000_0003;
    step();
    chk("r_c1_cs", {63'd0, ram_cs}, 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("r_cs_drop",   {63'd0, ram_cs}, 64'd0);
    chk("r_oe_drop",   {63'd0, ram_oe}, 64'd0);
    chk("r_busy_drop", {63'd0, busy},   64'd0);
    if_req = 1'b0;
    step();
    reset = 1'b1;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (if_done || d_done) stray++;
    end
    chk("r_no_stray_done", stray, 0);
    if_req = 1'b1; if_addr = 64'h8000; ram_rdata = 64'h0000_0000_0000_ABCD;
    wait_done(1'b0, 8, n);
    chk("r_next_lat",   n,        3);
    chk("r_next_rdata", rdata,    64'h0000_0000_0000_ABCD);
    chk("r_next_addr",  ram_addr, 64'h8000);
    if_req = 1'b0;
    step();
    step();
    chk("end_idle", {63'd0, busy}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
